// File: rtl/fg_dac_interface.sv
// Write sequencer for an external 8-bit parallel DAC: setup / WR-low / hold timing plus power-down and clear handling.
// Optional one-entry pending buffer for samples arriving while busy: define FG_DAC_PENDING_BUFFER_EN.
module fg_dac_interface #(
  parameter int BITWIDTH     = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int WR_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [BITWIDTH-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic                overrun_clr_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_pd_n_o,
  output logic                dac_clr_n_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_WAKE   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

  // Counter is loaded with N-1 on state entry so each state lasts exactly N cycles.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WR_LD    = 8'(WR_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAKE_LD  = 8'(WAKE_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                wr_n_q, wr_n_d;
  logic                pd_n_q, pd_n_d;
  logic                clr_n_q;
  logic                overrun_q, overrun_d;
  logic                busy;
  logic                cnt_done;
  logic                lost;

`ifdef FG_DAC_PENDING_BUFFER_EN
  logic                pend_valid_q, pend_valid_d;
  logic [BITWIDTH-1:0] pend_data_q, pend_data_d;
`endif

  assign busy     = (state_q == ST_WAKE) || (state_q == ST_SETUP) ||
                    (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign cnt_done = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - 8'd1;
    data_d  = data_q;
    lost    = 1'b0;
`ifdef FG_DAC_PENDING_BUFFER_EN
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (busy && sample_valid_i) begin
      pend_valid_d = 1'b1;
      pend_data_d  = sample_i;
      lost         = pend_valid_q;
    end
`else
    if (busy && sample_valid_i) begin
      lost = 1'b1;
    end
`endif

    case (state_q)
      ST_OFF: begin
        if (enable_i) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LD;
        end
      end
      ST_WAKE: begin
        if (!enable_i) begin
          state_d = ST_OFF;
`ifdef FG_DAC_PENDING_BUFFER_EN
          pend_valid_d = 1'b0;
`endif
        end else if (cnt_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!enable_i) begin
          state_d = ST_OFF;
`ifdef FG_DAC_PENDING_BUFFER_EN
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          // A sample captured during WAKE goes first; a same-cycle arrival queues behind it.
          data_d       = pend_data_q;
          state_d      = ST_SETUP;
          cnt_d        = SETUP_LD;
          pend_valid_d = sample_valid_i;
          pend_data_d  = sample_i;
`endif
        end else if (sample_valid_i) begin
          data_d  = sample_i;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d = ST_STROBE;
          cnt_d   = WR_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
`ifdef FG_DAC_PENDING_BUFFER_EN
          if (enable_i && pend_valid_d) begin
            data_d       = pend_data_d;
            pend_valid_d = 1'b0;
            state_d      = ST_SETUP;
            cnt_d        = SETUP_LD;
          end else if (!enable_i) begin
            pend_valid_d = 1'b0;
            state_d      = ST_OFF;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = enable_i ? ST_IDLE : ST_OFF;
`endif
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    wr_n_d    = (state_d != ST_STROBE);
    pd_n_d    = (state_d != ST_OFF);
    overrun_d = lost | (overrun_q & ~overrun_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      cnt_q     <= 8'd0;
      data_q    <= '0;
      wr_n_q    <= 1'b1;
      pd_n_q    <= 1'b0;
      clr_n_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FG_DAC_PENDING_BUFFER_EN
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      wr_n_q    <= wr_n_d;
      pd_n_q    <= pd_n_d;
      clr_n_q   <= 1'b1;
      overrun_q <= overrun_d;
`ifdef FG_DAC_PENDING_BUFFER_EN
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
`endif
    end
  end

  assign dac_data_o  = data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_pd_n_o  = pd_n_q;
  assign dac_clr_n_o = clr_n_q;
  assign busy_o      = busy;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_fg_dac_interface.sv
// Scoreboard bench for fg_dac_interface: directed writes push expected DAC data; a monitor checks every WR pulse.
module tb_fg_dac_interface;

  localparam int EXP_WIDTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       sample_valid = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] dac_data;
  logic       dac_wr_n, dac_pd_n, dac_clr_n, busy, overrun;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  time        fall_t[$];

  fg_dac_interface dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .overrun_clr_i  (overrun_clr),
    .dac_data_o     (dac_data),
    .dac_wr_n_o     (dac_wr_n),
    .dac_pd_n_o     (dac_pd_n),
    .dac_clr_n_o    (dac_clr_n),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !dac_wr_n) && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: observes WR pulses on the falling clock edge, checks data stability, width and value.
  initial begin : monitor
    logic       prev_wr;
    logic [7:0] cap;
    logic [7:0] exp_d;
    int         width;
    logic       abort;
    prev_wr = 1'b1;
    width   = 0;
    abort   = 1'b0;
    cap     = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_wr && !dac_wr_n) begin
        width = 1;
        cap   = dac_data;
        abort = rst;
        fall_t.push_back($time);
      end else if (!prev_wr && !dac_wr_n) begin
        width++;
        abort = abort | rst;
        chk("data_stable", {24'd0, dac_data}, {24'd0, cap});
      end else if (!prev_wr && dac_wr_n) begin
        if (!(abort || rst)) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", {24'd0, cap}, 32'hFFFF_FFFF);
          end else begin
            exp_d = sb.pop_front();
            chk("wr_data", {24'd0, cap}, {24'd0, exp_d});
            chk("wr_width", width, EXP_WIDTH);
          end
        end
      end
      prev_wr = dac_wr_n;
    end
  end

  initial begin : stim
    repeat (3) step();
    chk("rst_wr_n", {31'd0, dac_wr_n}, 32'd1);
    chk("rst_pd_n", {31'd0, dac_pd_n}, 32'd0);
    chk("rst_clr_n", {31'd0, dac_clr_n}, 32'd0);
    chk("rst_data", {24'd0, dac_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    rst = 1'b0;
    step();
    chk("clr_n_release", {31'd0, dac_clr_n}, 32'd1);
    chk("pd_n_before_en", {31'd0, dac_pd_n}, 32'd0);

    // Wake-up sequencing
    enable = 1'b1;
    step();
    chk("wake_pd_n", {31'd0, dac_pd_n}, 32'd1);
    chk("wake_busy", {31'd0, busy}, 32'd1);
    repeat (3) step();
    chk("wake_busy_late", {31'd0, busy}, 32'd1);
    step();
    chk("wake_idle", {31'd0, busy}, 32'd0);

    // Single write 0xA5 with exact pulse placement
    sample = 8'hA5; sample_valid = 1'b1; sb.push_back(8'hA5);
    step();
    sample_valid = 1'b0;
    chk("a5_data", {24'd0, dac_data}, 32'hA5);
    chk("a5_setup_wr", {31'd0, dac_wr_n}, 32'd1);
    step();
    chk("a5_strobe1", {31'd0, dac_wr_n}, 32'd0);
    step();
    chk("a5_strobe2", {31'd0, dac_wr_n}, 32'd0);
    step();
    chk("a5_hold_wr", {31'd0, dac_wr_n}, 32'd1);
    chk("a5_hold_busy", {31'd0, busy}, 32'd1);
    step();
    chk("a5_idle", {31'd0, busy}, 32'd0);
    chk("a5_data_kept", {24'd0, dac_data}, 32'hA5);

    // Two valids two cycles apart
    fall_t.delete();
    sample = 8'h11; sample_valid = 1'b1; sb.push_back(8'h11);
    step();
    sample_valid = 1'b0;
    step();
    sample = 8'h22; sample_valid = 1'b1;
`ifdef FG_DAC_PENDING_BUFFER_EN
    sb.push_back(8'h22);
`endif
    step();
    sample_valid = 1'b0;
    wait_idle();
    step();
`ifdef FG_DAC_PENDING_BUFFER_EN
    chk("b2b_pulses", fall_t.size(), 2);
    if (fall_t.size() == 2) chk("b2b_period", 32'(fall_t[1] - fall_t[0]), 32'd40);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
`else
    chk("b2b_pulses", fall_t.size(), 1);
    chk("b2b_overrun", {31'd0, overrun}, 32'd1);
`endif
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("b2b_clr", {31'd0, overrun}, 32'd0);

    // Three valids within one transaction
    sample = 8'h31; sample_valid = 1'b1; sb.push_back(8'h31);
    step();
    sample = 8'h32;
    step();
    sample = 8'h33;
`ifdef FG_DAC_PENDING_BUFFER_EN
    sb.push_back(8'h33);
`endif
    step();
    sample_valid = 1'b0;
    chk("three_overrun", {31'd0, overrun}, 32'd1);
    wait_idle();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clear", {31'd0, overrun}, 32'd0);

    // Clear in the same cycle as a new overrun: set wins
    sample = 8'h41; sample_valid = 1'b1; sb.push_back(8'h41);
    step();
    sample = 8'h42;
    step();
    sample = 8'h43; overrun_clr = 1'b1;
`ifdef FG_DAC_PENDING_BUFFER_EN
    sb.push_back(8'h43);
`endif
    step();
    sample_valid = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    wait_idle();

    // Disable during STROBE: pulse and hold complete, pending discarded
    sample = 8'h55; sample_valid = 1'b1; sb.push_back(8'h55);
    step();
    sample = 8'h56;
    step();
    sample_valid = 1'b0; enable = 1'b0;
    step();
    chk("dis_strobe", {31'd0, dac_wr_n}, 32'd0);
    step();
    chk("dis_hold_wr", {31'd0, dac_wr_n}, 32'd1);
    chk("dis_hold_pd", {31'd0, dac_pd_n}, 32'd1);
    step();
    chk("dis_off_pd", {31'd0, dac_pd_n}, 32'd0);
    chk("dis_off_busy", {31'd0, busy}, 32'd0);

    enable = 1'b1;
    repeat (5) step();
    chk("reen_idle", {31'd0, busy}, 32'd0);
    chk("reen_no_stale", {31'd0, dac_wr_n}, 32'd1);

    // Reset during STROBE
    sample = 8'h77; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    chk("rstx_strobe", {31'd0, dac_wr_n}, 32'd0);
    rst = 1'b1; enable = 1'b0;
    step();
    chk("rstx_wr_n", {31'd0, dac_wr_n}, 32'd1);
    chk("rstx_pd_n", {31'd0, dac_pd_n}, 32'd0);
    chk("rstx_clr_n", {31'd0, dac_clr_n}, 32'd0);
    chk("rstx_data", {24'd0, dac_data}, 32'd0);
    rst = 1'b0;
    repeat (4) step();
    chk("rstx_clr_n_rel", {31'd0, dac_clr_n}, 32'd1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fg_dac_interface.md
# fg_dac_interface

Write sequencer between the function generator core and the external 8-bit parallel DAC. It turns the core's one-cycle output-valid strobe into a correctly timed parallel write: data setup, an active-low WR pulse of fixed width, then data hold. It also handles DAC power-down and wake-up sequencing from the generator enable, and drives the active-low clear line. It replaces the direct combinational drive of the DAC control pins in the top level.

## Interface
Parameters:
- BITWIDTH, 8, sample and DAC data width
- SETUP_CYCLES, 1, cycles of data valid before WR falls; legal range 1..255
- WR_CYCLES, 2, width of WR low in cycles; legal range 1..255; at 50 MHz this gives more than 20 ns
- HOLD_CYCLES, 1, cycles of data held after WR rises; legal range 1..255
- WAKE_CYCLES, 4, cycles from power-down release to first permitted write; legal range 1..255

Ports:
- clk_i  in  1  system clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  generator enable (already synchronised)
- sample_i  in  BITWIDTH  sample from the function generator
- sample_valid_i  in  1  one-cycle strobe; sample_i is valid in that cycle
- overrun_clr_i  in  1  clears overrun_o
- dac_data_o  out  BITWIDTH  DAC parallel data, registered
- dac_wr_n_o  out  1  DAC write strobe, active low, registered
- dac_pd_n_o  out  1  DAC power-down, active low, registered
- dac_clr_n_o  out  1  DAC clear, active low, registered
- busy_o  out  1  high in WAKE, SETUP, STROBE and HOLD
- overrun_o  out  1  sticky flag: a sample was lost

## Operation
- FSM states: OFF, WAKE, IDLE, SETUP, STROBE, HOLD.
- A single 8-bit down-counter times every state.
- OFF:
  - dac_pd_n_o = 0.
  - sample_valid_i is ignored; no overrun is flagged.
  - enable_i = 1 moves to WAKE and loads WAKE_CYCLES.
- WAKE:
  - dac_pd_n_o = 1.
  - Moves to IDLE when the counter expires.
  - enable_i = 0 during WAKE returns to OFF.
- IDLE:
  - If enable_i = 0, go to OFF.
  - Else if sample_valid_i = 1, load dac_data_o from sample_i and go to SETUP.
- SETUP (SETUP_CYCLES): dac_wr_n_o = 1, data stable.
- STROBE (WR_CYCLES): dac_wr_n_o = 0, data stable.
- HOLD (HOLD_CYCLES): dac_wr_n_o = 1, data stable.
- At the end of HOLD:
  - If a pending sample exists and enable_i = 1, load it into dac_data_o, clear pending, and go straight to SETUP.
  - Else if enable_i = 0, go to OFF.
  - Else go to IDLE.
- Disabling mid-transaction: a transaction that has started always completes through HOLD. Pending data is then discarded.
- dac_data_o changes only on the load edge into SETUP, never during SETUP, STROBE or HOLD.
- A sample_valid_i arriving while busy (WAKE, SETUP, STROBE, HOLD) is handled as described under Configuration.
- overrun_o:
  - Set on any lost sample.
  - Cleared by overrun_clr_i or reset.
  - If set and clear happen in the same cycle, set wins.
- dac_clr_n_o is 0 while rst_i = 1. It is registered to 1 on the first cycle after reset deasserts.

## Timing
- Reset values:
  - state = OFF
  - dac_data_o = 0
  - dac_wr_n_o = 1
  - dac_pd_n_o = 0
  - dac_clr_n_o = 0
  - busy_o = 0
  - overrun_o = 0
  - pending empty
- Reset asserted mid-transaction aborts immediately to the reset values. dac_wr_n_o returns to 1 on the next edge.
- Latency and pulse shape, for a valid accepted at edge t in IDLE:
  - dac_data_o is updated at t+1.
  - dac_wr_n_o falls at t+1+SETUP_CYCLES.
  - dac_wr_n_o rises at t+1+SETUP_CYCLES+WR_CYCLES.
  - The FSM is back in IDLE at t+1+SETUP_CYCLES+WR_CYCLES+HOLD_CYCLES.
- Back-to-back writes from pending repeat with a period of SETUP_CYCLES+WR_CYCLES+HOLD_CYCLES.
- Enable:
  - enable_i rising at edge t in OFF gives dac_pd_n_o = 1 at t+1 and IDLE at t+1+WAKE_CYCLES.
  - enable_i falling in IDLE gives dac_pd_n_o = 0 on the next edge.

## Configuration
- FG_DAC_PENDING_BUFFER_EN defined:
  - A one-entry pending register captures a sample_valid_i that arrives while busy.
  - If the register is already full, the new sample overwrites it and overrun_o is set.
  - Samples captured during WAKE are written as soon as IDLE is reached.
- Undefined:
  - There is no pending register.
  - Any sample_valid_i while busy is dropped and sets overrun_o.
  - After HOLD the FSM always goes to IDLE or OFF.

## Test plan
- Reset, then enable_i = 1 at cycle 0 with defaults: dac_pd_n_o = 1 at cycle 1, busy_o low at cycle 5. Before enable, dac_clr_n_o = 1 one cycle after rst_i falls.
- In IDLE, sample 0xA5 valid at edge t: dac_data_o = 0xA5 at t+1, dac_wr_n_o low exactly during t+2..t+3, IDLE at t+5, no glitch on dac_data_o.
- Two valids 2 cycles apart (0x11, 0x22) with the macro defined: two WR pulses 4 cycles apart, data 0x11 then 0x22, overrun_o = 0. Without the macro: one pulse only and overrun_o = 1.
- Three valids during one transaction with the macro defined: the last value is written second, overrun_o = 1. Then overrun_clr_i pulse gives overrun_o = 0 next cycle; clear together with a new overrun leaves it 1.
- enable_i falls during STROBE: the WR pulse completes full width, HOLD completes, then OFF with dac_pd_n_o = 0 and any pending sample discarded.
- rst_i asserted during STROBE: next edge gives dac_wr_n_o = 1, dac_pd_n_o = 0, dac_clr_n_o = 0, dac_data_o = 0.
